// File: rtl/st_frame_arbiter.sv
// rtl/st_frame_arbiter.sv - two-requester frame-locked round-robin arbiter
module st_frame_arbiter #(
    parameter int DATA_WIDTH = 36,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in0_valid,
    input  logic [DATA_WIDTH-1:0] in0_data,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  in1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    input  logic                  out_ready,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic                  last_owner_q, last_owner_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  accept;

    // Sequencing state; last_owner resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Owner selection, zero-latency datapath mux and frame bookkeeping.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid    = 1'b0;
        out_data     = '0;
        out_sop      = 1'b0;
        out_eop      = 1'b0;
        in0_ready    = 1'b0;
        in1_ready    = 1'b0;
        grant        = 2'b00;
        accept       = 1'b0;

        case (state_q)
            IDLE: begin
                // Arbitration only; the bubble cycle keeps out_valid off out_ready.
                if (in0_valid && in1_valid) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (in0_valid) begin
                    state_d = OWN0;
                end else if (in1_valid) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                grant     = 2'b01;
                out_valid = in0_valid;
                out_data  = in0_data;
                in0_ready = out_ready;
                out_sop   = (beat_cnt_q == '0);
                out_eop   = (beat_cnt_q == LAST_BEAT);
            end
            OWN1: begin
                grant     = 2'b10;
                out_valid = in1_valid;
                out_data  = in1_data;
                in1_ready = out_ready;
                out_sop   = (beat_cnt_q == '0);
                out_eop   = (beat_cnt_q == LAST_BEAT);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = out_valid && out_ready;
        if (accept) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d   = '0;
                last_owner_d = (state_q == OWN1);
                state_d      = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_ONE;
            end
        end
    end

    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_st_frame_arbiter.sv
// tb/tb_st_frame_arbiter.sv - directed self-checking bench for st_frame_arbiter
module tb_st_frame_arbiter;

    localparam int DW = 36;
    localparam int FL = 256;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in0_valid, in1_valid;
    logic [DW-1:0] in0_data, in1_data;
    logic          in0_ready, in1_ready;
    logic          out_valid, out_sop, out_eop, out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    grant;
    logic [CW-1:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    st_frame_arbiter #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_ready (out_ready),
        .grant     (grant),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int who, input int idx);
        logic [3:0]  tagbits;
        logic [31:0] body;
        tagbits = 4'(who + 1);
        body    = 32'(idx * 3 + 7);
        return {tagbits, body};
    endfunction

    task automatic drive(input int who, input logic own_v, input logic oth_v, input int idx);
        if (who == 0) begin
            in0_valid = own_v;
            in1_valid = oth_v;
            in0_data  = mk(0, idx);
            in1_data  = mk(1, 500 + idx);
        end else begin
            in1_valid = own_v;
            in0_valid = oth_v;
            in1_data  = mk(1, idx);
            in0_data  = mk(0, 500 + idx);
        end
    endtask

    function automatic logic own_ready(input int who);
        return (who == 0) ? in0_ready : in1_ready;
    endfunction

    function automatic logic oth_ready(input int who);
        return (who == 0) ? in1_ready : in0_ready;
    endfunction

    // Entry and exit: one time unit after a rising edge, DUT in IDLE.
    task automatic run_frame(input int who, input int oth_on_at, input int stall_at,
                             input int stall_len, input int drop_at, input int drop_len,
                             input int abort_at);
        logic [1:0] g;
        logic       ov;
        g = (who == 0) ? 2'b01 : 2'b10;
        drive(who, 1'b1, (oth_on_at == 0), 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bubble_grant", grant, 2'b00);
        check("bubble_valid", out_valid, 1'b0);
        check("bubble_ready", own_ready(who), 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < FL; i++) begin
            ov = (oth_on_at >= 0) && (i >= oth_on_at);
            if (i == drop_at) begin
                for (int k = 0; k < drop_len; k++) begin
                    drive(who, 1'b0, 1'b1, i);
                    @(negedge clk);
                    check("drop_grant", grant, g);
                    check("drop_valid", out_valid, 1'b0);
                    check("drop_oth_ready", oth_ready(who), 1'b0);
                    check("drop_cnt", beat_cnt, i);
                    @(posedge clk); #1;
                end
            end
            if (i == stall_at) begin
                drive(who, 1'b1, ov, i);
                out_ready = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check("stall_cnt", beat_cnt, i);
                    check("stall_data", out_data, mk(who, i));
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_ready", own_ready(who), 1'b0);
                    check("stall_eop", out_eop, (i == FL - 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            drive(who, 1'b1, ov, i);
            @(negedge clk);
            check("grant", grant, g);
            check("valid", out_valid, 1'b1);
            check("data", out_data, mk(who, i));
            check("sop", out_sop, (i == 0));
            check("eop", out_eop, (i == FL - 1));
            check("cnt", beat_cnt, i);
            check("own_ready", own_ready(who), 1'b1);
            check("oth_ready", oth_ready(who), 1'b0);
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                in0_valid = 1'b0;
                in1_valid = 1'b0;
                @(negedge clk);
                check("abort_grant", grant, 2'b00);
                check("abort_cnt", beat_cnt, 0);
                check("abort_eop", out_eop, 1'b0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_cnt", beat_cnt, 0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_sop", out_sop, 1'b0);
        check("rst_ready0", in0_ready, 1'b0);
        check("rst_ready1", in1_ready, 1'b0);
        @(posedge clk); #1;

        // single requester, full frame
        run_frame(0, -1, -1, 0, -1, 0, -1);

        // both valid from reset: 0,1,0,1
        do_reset();
        run_frame(0, 0, -1, 0, -1, 0, -1);
        run_frame(1, 0, -1, 0, -1, 0, -1);
        run_frame(0, 0, -1, 0, -1, 0, -1);
        run_frame(1, 0, -1, 0, -1, 0, -1);

        // in1 arrives mid in0 frame, gets the next frame
        run_frame(0, 120, -1, 0, -1, 0, -1);
        run_frame(1, -1, -1, 0, -1, 0, -1);

        // backpressure at beat 100 for 5 cycles
        run_frame(0, -1, 100, 5, -1, 0, -1);

        // owner valid drops 3 cycles with the other valid
        run_frame(0, -1, -1, 0, 60, 3, -1);

        // reset at beat 50 of an in1 frame, then in0 wins the tie
        run_frame(1, -1, -1, 0, -1, 0, 50);
        run_frame(0, 0, -1, 0, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
